// File: rtl/interrupt_priority_unit_if.sv
// Request/priority bundle between the 8259 control block and
// the interrupt priority unit.
interface interrupt_priority_unit_if;
    logic [7:0] irq_in;
    logic       level_or_edge_triggered;
    logic       clear_state;
    logic [7:0] int_mask;
    logic       special_mask_mode;
    logic [7:0] eoi;
    logic       latch_in_service;
    logic       freeze;
    logic       priority_rotate;
    logic [2:0] rotate_to;
    logic       auto_rotate;
    logic [7:0] interrupt_request_reg;
    logic [7:0] in_service_reg;
    logic [7:0] highest_level_in_service;
    logic [7:0] interrupt_to_service;
    logic [2:0] vector_level;
    logic       interrupt;

    modport master (
        output irq_in, level_or_edge_triggered, clear_state,
        output int_mask, special_mask_mode, eoi,
        output latch_in_service, freeze,
        output priority_rotate, rotate_to, auto_rotate,
        input  interrupt_request_reg, in_service_reg,
        input  highest_level_in_service,
        input  interrupt_to_service, vector_level, interrupt
    );

    modport slave (
        input  irq_in, level_or_edge_triggered, clear_state,
        input  int_mask, special_mask_mode, eoi,
        input  latch_in_service, freeze,
        input  priority_rotate, rotate_to, auto_rotate,
        output interrupt_request_reg, in_service_reg,
        output highest_level_in_service,
        output interrupt_to_service, vector_level, interrupt
    );
endinterface

// File: rtl/interrupt_priority_unit.sv
// 8259 request/priority stage: IR sync, IRR/ISR and fixed or
// rotating priority resolution feeding the control block.
module interrupt_priority_unit #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    interrupt_priority_unit_if.slave bus
);
    typedef logic [NUM_IRQ-1:0] vec_t;

    function automatic vec_t rot_r(input vec_t v, input logic [2:0] s);
        logic [2*NUM_IRQ-1:0] w;
        w = {v, v} >> s;
        return w[NUM_IRQ-1:0];
    endfunction

    function automatic vec_t rot_l(input vec_t v, input logic [2:0] s);
        logic [2*NUM_IRQ-1:0] w;
        w = {v, v} << s;
        return w[2*NUM_IRQ-1:NUM_IRQ];
    endfunction

    function automatic vec_t low_bit(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    function automatic logic [2:0] encode(input vec_t v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (v[i]) r = r | 3'(i);
        return r;
    endfunction

    vec_t       sync_q [SYNC_STAGES];
    vec_t       irq_s;
    vec_t       irq_d;
    vec_t       irr_q;
    vec_t       irr_nxt;
    vec_t       isr_q;
    vec_t       its_q;
    vec_t       hlis;
    vec_t       req_r;
    vec_t       blk_r;
    vec_t       allow_r;
    vec_t       win;
    vec_t       eoi_top;
    logic [2:0] vl_q;
    logic [2:0] lowest_q;
    logic [2:0] shift;
    logic       int_q;
    logic       level;

    assign irq_s = sync_q[SYNC_STAGES-1];
    assign level = bus.level_or_edge_triggered;
    assign shift = lowest_q + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.irq_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    // Level mode never clears on latch: the pin is simply re-sampled.
    always_comb begin
        irr_nxt = irr_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.latch_in_service && its_q[i] && !level)
                irr_nxt[i] = 1'b0;
            else if (!irq_s[i])
                irr_nxt[i] = 1'b0;
            else if (level || !irq_d[i])
                irr_nxt[i] = 1'b1;
        end
    end

    // Work in the rotated domain so bit 0 is always the top level.
    always_comb begin
        req_r = rot_r(irr_q & ~bus.int_mask, shift);
        if (bus.special_mask_mode)
            blk_r = low_bit(rot_r(isr_q & ~bus.int_mask, shift));
        else
            blk_r = low_bit(rot_r(isr_q, shift));
        allow_r = (blk_r == '0) ? '1 : blk_r - vec_t'(1);
        win     = rot_l(low_bit(req_r & allow_r), shift);
        hlis    = rot_l(low_bit(rot_r(isr_q, shift)), shift);
        eoi_top = rot_l(low_bit(rot_r(bus.eoi, shift)), shift);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irr_q    <= '0;
            irq_d    <= '0;
            isr_q    <= '0;
            its_q    <= '0;
            vl_q     <= '0;
            int_q    <= 1'b0;
            lowest_q <= 3'd7;
        end else if (bus.clear_state) begin
            irr_q    <= '0;
            irq_d    <= '0;
            isr_q    <= '0;
            its_q    <= '0;
            vl_q     <= '0;
            int_q    <= 1'b0;
            lowest_q <= 3'd7;
        end else begin
            irq_d <= irq_s;
            isr_q <= (isr_q & ~bus.eoi)
                   | (bus.latch_in_service ? its_q : '0);
            if (!bus.freeze) begin
                irr_q <= irr_nxt;
                its_q <= win;
                vl_q  <= encode(win);
                int_q <= |win;
            end
            if (bus.priority_rotate)
                lowest_q <= bus.rotate_to;
            else if (bus.auto_rotate && |bus.eoi)
                lowest_q <= encode(eoi_top);
        end
    end

    assign bus.interrupt_request_reg    = irr_q;
    assign bus.in_service_reg           = isr_q;
    assign bus.highest_level_in_service = hlis;
    assign bus.interrupt_to_service     = its_q;
    assign bus.vector_level             = vl_q;
    assign bus.interrupt                = int_q;
endmodule

// File: doc/interrupt_priority_unit.md
Name: interrupt_priority_unit

Overview:
Request/priority stage of the 8259 PIC, directly upstream of the control block. It synchronises the IR pins, holds the interrupt request register (IRR) and in-service register (ISR), and resolves the winning request under fixed or rotating priority.
- Consumes from control: int_mask, eoi, latch_in_service and the rotation commands.
- Produces for control: highest_level_in_service and the INT request.

Parameters:
NUM_IRQ, 8, number of request lines; must be 8 (the 3-bit priority pointer and vector field assume 8).
SYNC_STAGES, 2, flop stages on each irq_in bit; minimum 1.

Ports:
clk  input  1  system clock; all state is updated on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
irq_in  input  8  raw IR0..IR7 pins.
level_or_edge_triggered  input  1  ICW1 LTIM bit: 1 = level-triggered, 0 = edge-triggered.
clear_state  input  1  single-cycle pulse on a write_ICW1 event.
int_mask  input  8  IMR from OCW1; 1 = masked.
special_mask_mode  input  1  OCW3 SMM enable.
eoi  input  8  one-hot/multi-hot ISR clear vector.
latch_in_service  input  1  single-cycle pulse: move the current winner into the ISR.
freeze  input  1  hold IRR and the winner during an INTA sequence.
priority_rotate  input  1  single-cycle pulse: load the lowest-priority pointer from rotate_to.
rotate_to  input  3  new lowest-priority level.
auto_rotate  input  1  when high, a non-zero eoi also rotates priority.
interrupt_request_reg  output  8  IRR.
in_service_reg  output  8  ISR.
highest_level_in_service  output  8  one-hot highest-priority ISR bit, or 0.
interrupt_to_service  output  8  registered one-hot winner, or 0.
vector_level  output  3  binary index of interrupt_to_service.
interrupt  output  1  registered INT request.

Behaviour:
- Reset: every register clears asynchronously, including mid-sequence.
  - All outputs reset to 0.
  - Sync chains and edge history reset to 0.
  - lowest_level resets to 7 (IR0 highest priority).
- Sync: irq_s = irq_in delayed SYNC_STAGES cycles. irq_d = irq_s delayed one further cycle, used for edge detection.
- IRR, per bit, with freeze=0, in priority order:
  1. clear_state: clear.
  2. latch_in_service with interrupt_to_service[i]: clear (edge mode only; in level mode the bit is re-evaluated from the pin next cycle).
  3. irq_s=0: clear.
  4. Edge mode, irq_s & ~irq_d: set.
  5. Level mode, irq_s: set.
  6. Otherwise: hold.
  - With freeze=1, IRR holds. Edge history still tracks, so an edge during freeze is lost. This matches the device.
- Priority order: after rotation, the highest priority is level (lowest_level+1) mod 8, falling to lowest_level.
  - Resolve by rotating the vector right by (lowest_level+1), taking the lowest set bit, then rotating back.
  - Modulo-8 wrap is required.
- Eligibility: req = IRR & ~int_mask.
  - Normal mode: the winner must be strictly higher priority than highest_level_in_service. An equal or lower level is blocked.
  - Special mask mode: compare against the highest bit of ISR & ~int_mask instead. Masked in-service levels do not block.
- Winner: when freeze=0, interrupt_to_service, vector_level and interrupt register the resolution result each cycle. With freeze=1 they hold. Latency from an irq_in edge to interrupt=1 is SYNC_STAGES+2 cycles.
- ISR: next = (ISR & ~eoi) | (latch_in_service ? interrupt_to_service : 0). If set and clear hit the same bit in the same cycle, set wins.
  - clear_state clears the ISR.
  - latch_in_service with interrupt_to_service=0 (spurious request) is a no-op.
- highest_level_in_service: combinational from the ISR register and lowest_level, using the same rotation as the priority order.
- Rotation:
  - priority_rotate: lowest_level <= rotate_to.
  - Otherwise, if auto_rotate and eoi is non-zero: lowest_level <= index of the highest-priority set bit of eoi.
  - priority_rotate has precedence over auto_rotate.
  - clear_state forces lowest_level to 7.
- clear_state is a synchronous clear of IRR, ISR, winner, interrupt and edge history. It takes precedence over every other same-cycle event.

Test Plan:
1. Fixed priority, edge mode, mask 0x00, irq_in 0x00->0x24: interrupt=1 after SYNC_STAGES+2 cycles; interrupt_to_service=0x04, vector_level=2. latch_in_service -> ISR=0x04 and IRR=0x20, while interrupt stays 0 (IR5 is blocked by IR2). eoi=0x04 -> IR5 is serviced, interrupt_to_service=0x20.
2. Masking: IRR=0x03, mask=0x01 -> winner 0x02. Set mask=0x03 -> interrupt=0 next cycle.
3. Rotation: priority_rotate with rotate_to=3, requests 0x09 -> winner 0x10? No: requests 0x09 (IR0, IR3) -> winner 0x01, because IR4..IR7 are empty and IR0 follows. Then auto_rotate=1 with eoi=0x01 -> lowest_level=0, and requests 0x09 -> winner 0x08.
4. Special mask mode: ISR=0x01, mask=0x01, request IR4 -> winner 0x10 with SMM=1; interrupt=0 with SMM=0.
5. Level vs edge: hold irq_in[6]=1 across a latch. Level mode -> IRR[6] is set again next cycle. Edge mode -> IRR[6] stays 0 until the pin falls and rises again.
6. Reset/clear: assert reset_n=0 mid-sequence, with ISR=0x81 and freeze=1 -> all outputs 0 immediately and lowest_level=7. Repeat with clear_state together with latch_in_service -> ISR=0x00.
